// File: rtl/seg7_readback.sv
// Reads back an active-low 5-digit 7-segment bus and reconstructs the signed 12-bit value shown.
// Each new pattern is decoded once, after it has stayed unchanged long enough.
module seg7_readback #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [39:0] seg7_in,
    output logic [11:0] value_out,
    output logic        valid_out,
    output logic        err_out,
    output logic        busy_out
);

    typedef enum logic [1:0] {IDLE, DECODE, FINISH} state_t;

    localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] STABLE_M1  = CNT_W'(STABLE_CYCLES - 1);

    state_t      state_reg;
    logic [39:0] prev_reg;
    logic [39:0] snap_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic        done_reg;
    logic [13:0] acc_reg;
    logic [1:0]  idx_reg;
    logic        neg_reg;
    logic        bad_reg;
    logic [11:0] value_reg;
    logic        valid_reg;
    logic        err_reg;

    // Returns {legal, blank, digit}; legal covers 0-9 and blank only.
    function automatic logic [5:0] seg_decode(input logic [6:0] raw);
        logic [6:0] s;
        s = ~raw;
        case (s)
            7'h3F:   seg_decode = {2'b10, 4'd0};
            7'h06:   seg_decode = {2'b10, 4'd1};
            7'h5B:   seg_decode = {2'b10, 4'd2};
            7'h4F:   seg_decode = {2'b10, 4'd3};
            7'h66:   seg_decode = {2'b10, 4'd4};
            7'h6D:   seg_decode = {2'b10, 4'd5};
            7'h7D:   seg_decode = {2'b10, 4'd6};
            7'h07:   seg_decode = {2'b10, 4'd7};
            7'h7F:   seg_decode = {2'b10, 4'd8};
            7'h6F:   seg_decode = {2'b10, 4'd9};
            7'h00:   seg_decode = {2'b11, 4'd0};
            default: seg_decode = {2'b00, 4'd0};
        endcase
    endfunction

    logic [5:0] dec [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dig
            assign dec[gi] = seg_decode(snap_reg[8*gi +: 7]);
        end
    endgenerate

    logic [5:0]  cur_dec;
    logic        cur_bad;
    logic [13:0] acc_next;
    logic        same;
    logic        stable_hit;
    logic [6:0]  sign_seg;
    logic        sign_neg;
    logic        sign_bad;

    assign cur_dec  = dec[idx_reg];
    assign cur_bad  = !cur_dec[5] || ((idx_reg == 2'd0) && cur_dec[4]);
    assign acc_next = (acc_reg << 3) + (acc_reg << 1) + {10'd0, cur_dec[3:0]};
    assign same     = (seg7_in == prev_reg);
    // Counter reaching its target on this edge is enough to start; saves a cycle of latency.
    assign stable_hit = same && (cnt_reg >= STABLE_M1) && !done_reg;
    assign sign_seg = ~seg7_in[38:32];
    assign sign_neg = (sign_seg == 7'h40);
    assign sign_bad = (sign_seg != 7'h00) && !sign_neg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            prev_reg  <= '0;
            snap_reg  <= '0;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
            acc_reg   <= '0;
            idx_reg   <= '0;
            neg_reg   <= 1'b0;
            bad_reg   <= 1'b0;
            value_reg <= '0;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
            prev_reg  <= seg7_in;

            case (state_reg)
                IDLE: begin
                    if (stable_hit) begin
                        state_reg <= DECODE;
                        snap_reg  <= seg7_in;
                        acc_reg   <= '0;
                        idx_reg   <= 2'd3;
                        neg_reg   <= sign_neg;
                        bad_reg   <= sign_bad;
                    end
                end
                DECODE: begin
                    acc_reg <= acc_next;
                    bad_reg <= bad_reg | cur_bad;
                    if (idx_reg == 2'd0) begin
                        state_reg <= FINISH;
                    end else begin
                        idx_reg <= idx_reg - 2'd1;
                    end
                end
                FINISH: begin
                    if (bad_reg || (!neg_reg && acc_reg > 14'd2047) ||
                        (neg_reg && acc_reg > 14'd2048)) begin
                        err_reg <= 1'b1;
                    end else begin
                        value_reg <= neg_reg ? (12'd0 - acc_reg[11:0]) : acc_reg[11:0];
                        valid_reg <= 1'b1;
                    end
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase

            // A changed bus overrides whatever the FSM chose this cycle.
            if ((state_reg != IDLE) && (seg7_in != snap_reg)) begin
                state_reg <= IDLE;
                valid_reg <= 1'b0;
                err_reg   <= 1'b0;
                value_reg <= value_reg;
            end

            if (!same) begin
                cnt_reg  <= '0;
                done_reg <= 1'b0;
            end else if (cnt_reg < STABLE_MAX) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign value_out = value_reg;
    assign valid_out = valid_reg;
    assign err_out   = err_reg;
    assign busy_out  = (state_reg != IDLE);

endmodule

// File: tb/tb_seg7_readback.sv
// Scoreboard bench for seg7_readback: an independent decode model queues expected outcomes,
// a monitor pops and compares them whenever the DUT pulses valid_out or err_out.
module tb_seg7_readback;

    localparam int STABLE_CYCLES = 4;

    localparam logic [39:0] P_123  = 40'hFF_FF_F9_A4_B0;
    localparam logic [39:0] P_M2048 = 40'hBF_A4_C0_99_80;
    localparam logic [39:0] P_2047 = 40'hFF_A4_C0_99_F8;
    localparam logic [39:0] P_2048 = 40'hFF_A4_C0_99_80;
    localparam logic [39:0] P_SEGA = 40'hFF_FF_F9_A4_FE;
    localparam logic [39:0] P_BLNK = 40'hFF_FF_F9_A4_FF;
    localparam logic [39:0] P_456  = 40'hFF_FF_99_92_82;
    localparam logic [39:0] P_M0   = 40'hBF_C0_C0_C0_C0;
    localparam logic [39:0] P_789  = 40'hFF_FF_F8_80_90;

    logic        clk = 1'b0;
    logic        rst;
    logic [39:0] seg7_in;
    logic [11:0] value_out;
    logic        valid_out;
    logic        err_out;
    logic        busy_out;

    seg7_readback #(.STABLE_CYCLES(STABLE_CYCLES), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg7_in   (seg7_in),
        .value_out (value_out),
        .valid_out (valid_out),
        .err_out   (err_out),
        .busy_out  (busy_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [11:0] val;
        logic [39:0] pat;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [11:0] model_val = 12'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Digit code of one active-low byte: 0-9, 10 blank, 11 minus, 15 illegal.
    function automatic int digit_of(input logic [7:0] b);
        logic [7:0] s;
        s = ~b & 8'h7F;
        case (s)
            8'h3F: return 0;  8'h06: return 1;  8'h5B: return 2;  8'h4F: return 3;
            8'h66: return 4;  8'h6D: return 5;  8'h7D: return 6;  8'h07: return 7;
            8'h7F: return 8;  8'h6F: return 9;  8'h00: return 10; 8'h40: return 11;
            default: return 15;
        endcase
    endfunction

    function automatic exp_t model(input logic [39:0] p);
        exp_t e;
        int   d;
        int   mag;
        bit   neg;
        bit   bad;
        bad = 0;
        mag = 0;
        d = digit_of(p[39:32]);
        neg = (d == 11);
        if (d != 10 && d != 11) bad = 1;
        for (int i = 3; i >= 0; i--) begin
            d = digit_of(p[8*i +: 8]);
            if (d == 10 && i != 0) d = 0;
            if (d > 9) bad = 1;
            else mag = mag * 10 + d;
        end
        if (!neg && mag > 2047) bad = 1;
        if (neg && mag > 2048) bad = 1;
        e.pat = p;
        e.is_err = bad;
        if (!bad) model_val = neg ? 12'(-mag) : 12'(mag);
        e.val = model_val;
        return e;
    endfunction

    task automatic apply(input logic [39:0] p, input bit expect_result);
        @(negedge clk);
        seg7_in = p;
        if (expect_result) sb_q.push_back(model(p));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 60) begin
            @(posedge clk);
            t++;
        end
        check("drain", sb_q.size(), 0);
        repeat (4) @(posedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (valid_out || err_out) begin
                check("exclusive", {31'd0, valid_out && err_out}, 0);
                check("expected_pulse", {31'd0, sb_q.size() != 0}, 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("kind", {30'd0, valid_out, err_out}, e.is_err ? 32'd1 : 32'd2);
                    check("value", {20'd0, value_out}, {20'd0, e.val});
                    $display("txn pat=%010h valid=%0b err=%0b value=%03h", e.pat, valid_out,
                             err_out, value_out);
                end
            end
        end
    end

    initial begin : stim
        int lat;
        rst = 1'b1;
        seg7_in = 40'hFF_FF_FF_FF_FF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_value", {20'd0, value_out}, 0);
        check("rst_valid", {31'd0, valid_out}, 0);
        check("rst_err", {31'd0, err_out}, 0);
        check("rst_busy", {31'd0, busy_out}, 0);
        @(negedge clk);
        rst = 1'b0;
        sb_q.push_back(model(seg7_in));   // all blank: units blank is an error
        drain();

        // Latency from the first sampling edge of a new pattern.
        apply(P_123, 1);
        lat = -1;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (valid_out || err_out) begin
                lat = k;
                break;
            end
        end
        check("latency", lat, STABLE_CYCLES + 5);
        drain();

        apply(P_M2048, 1); drain();
        apply(P_2047, 1);  drain();
        apply(P_2048, 1);  drain();
        apply(P_SEGA, 1);  drain();
        apply(P_BLNK, 1);  drain();
        apply(P_M0, 1);    drain();

        // Change the bus while decoding: only the second pattern reports.
        apply(P_123, 0);
        repeat (6) @(posedge clk);
        #1;
        check("busy_decode", {31'd0, busy_out}, 1);
        apply(P_456, 1);
        drain();

        // Reset in the middle of a decode.
        apply(P_123, 0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_value", {20'd0, value_out}, 0);
        check("midrst_pulse", {30'd0, valid_out, err_out}, 0);
        check("midrst_busy", {31'd0, busy_out}, 0);
        model_val = 12'd0;
        @(negedge clk);
        rst = 1'b0;
        sb_q.push_back(model(P_123));
        drain();

        // One-cycle glitch is never decoded; the restored pattern is decoded once more.
        apply(P_789, 0);
        apply(P_123, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
